// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR datapath (MAC pipeline and FIR output stage).
//   FIR_MAX_W      widest intermediate used by the rounding/saturation helper
//   sat_round_t    result of sat_round: saturated value plus clip flag
//   acc_width_ok   parameter check: accumulator holds a full product
//   mult_stages_ok parameter check: multiplier has at least one register
//   sat_round      round half-up, arithmetic shift, then clip to out_width
// ---------------------------------------------------------------------------
package fir_pkg;

   localparam int FIR_MAX_W = 128;

   typedef struct packed {
      logic                        sat;
      logic signed [FIR_MAX_W-1:0] value;
   } sat_round_t;

   // The accumulator must be at least as wide as a full-precision product.
   // Two bits of headroom below FIR_MAX_W keep the rounding add from wrapping.
   function automatic bit acc_width_ok(input int acc_width, input int in0_width,
                                       input int in1_width);
      return (acc_width >= in0_width + in1_width) && (acc_width <= FIR_MAX_W - 2);
   endfunction

   function automatic bit mult_stages_ok(input int stages);
      return stages >= 1;
   endfunction

   // The caller sign-extends its value to FIR_MAX_W first, so the rounding
   // constant can be added without overflow; only the final clip can change
   // the magnitude.
   function automatic sat_round_t sat_round(input logic signed [FIR_MAX_W-1:0] value,
                                            input int shift, input int out_width);
      logic signed [FIR_MAX_W-1:0] one;
      logic signed [FIR_MAX_W-1:0] rounded;
      logic signed [FIR_MAX_W-1:0] max_pos;
      logic signed [FIR_MAX_W-1:0] min_neg;
      sat_round_t                  res;
      one     = FIR_MAX_W'(1);
      rounded = value;
      if (shift > 0) begin
         rounded = value + (one <<< (shift - 1));
      end
      rounded   = rounded >>> shift;
      max_pos   = (one <<< (out_width - 1)) - one;
      min_neg   = -(one <<< (out_width - 1));
      res.sat   = 1'b0;
      res.value = rounded;
      if (rounded > max_pos) begin
         res.sat   = 1'b1;
         res.value = max_pos;
      end else if (rounded < min_neg) begin
         res.sat   = 1'b1;
         res.value = min_neg;
      end
      return res;
   endfunction

endpackage

// File: rtl/mult_pipe.sv
// ---------------------------------------------------------------------------
// mult_pipe
// Full-precision signed multiplier followed by a STAGES-deep register chain.
// The valid/first/last sideband travels alongside the product so the
// accumulator sees each beat exactly as it was presented.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   valid, first, last input beat qualifier and frame delimiters
//   a, b               signed operands
//   prod_valid/first/last  delayed sideband
//   product            signed A_WIDTH+B_WIDTH product, STAGES cycles later
// ---------------------------------------------------------------------------
module mult_pipe #(
   parameter int A_WIDTH = 16,
   parameter int B_WIDTH = 16,
   parameter int STAGES  = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              valid,
   input  logic                              first,
   input  logic                              last,
   input  logic signed [A_WIDTH-1:0]         a,
   input  logic signed [B_WIDTH-1:0]         b,
   output logic                              prod_valid,
   output logic                              prod_first,
   output logic                              prod_last,
   output logic signed [A_WIDTH+B_WIDTH-1:0] product
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;

   logic signed [P_WIDTH-1:0] product_comb;
   logic signed [P_WIDTH-1:0] prod_q  [STAGES];
   logic                      valid_q [STAGES];
   logic                      first_q [STAGES];
   logic                      last_q  [STAGES];

   // Both operands are sign-extended to the product width so the multiply
   // is exact and signed.
   assign product_comb = P_WIDTH'(a) * P_WIDTH'(b);

   // Register chain: stage 0 captures the fresh product, later stages shift.
   // Every stage is cleared on reset so no stale beat can emerge afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            prod_q[s]  <= '0;
            valid_q[s] <= 1'b0;
            first_q[s] <= 1'b0;
            last_q[s]  <= 1'b0;
         end
      end else begin
         prod_q[0]  <= product_comb;
         valid_q[0] <= valid;
         first_q[0] <= first;
         last_q[0]  <= last;
         for (int s = 1; s < STAGES; s++) begin
            prod_q[s]  <= prod_q[s-1];
            valid_q[s] <= valid_q[s-1];
            first_q[s] <= first_q[s-1];
            last_q[s]  <= last_q[s-1];
         end
      end
   end

   assign product    = prod_q[STAGES-1];
   assign prod_valid = valid_q[STAGES-1];
   assign prod_first = first_q[STAGES-1];
   assign prod_last  = last_q[STAGES-1];

endmodule

// File: rtl/mac_pipe.sv
// ---------------------------------------------------------------------------
// mac_pipe
// Pipelined signed multiply-accumulate for the FIR datapath. Products are
// summed over frames delimited by first_i/last_i; each frame yields one
// rounded, saturated result with a one-cycle valid_o strobe.
// Latency from the last_i beat to valid_o is MULT_STAGES+2 cycles.
// Ports:
//   clk_i, rst_ni   clock (rising edge), asynchronous active-low reset
//   valid_i         in0_i/in1_i/first_i/last_i qualified this cycle
//   in0_i, in1_i    signed sample and coefficient
//   first_i         first product of a frame (accumulator restarts from 0)
//   last_i          last product of a frame (result emitted)
//   valid_o         single-cycle strobe for result_o/sat_o
//   result_o        rounded, saturated frame sum (holds until next valid_o)
//   sat_o           result_o was clipped
// ---------------------------------------------------------------------------
module mac_pipe #(
   parameter int IN0_WIDTH   = 16,
   parameter int IN1_WIDTH   = 16,
   parameter int ACC_WIDTH   = 40,
   parameter int OUT_WIDTH   = 16,
   parameter int OUT_SHIFT   = 15,
   parameter int MULT_STAGES = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        valid_i,
   input  logic signed [IN0_WIDTH-1:0] in0_i,
   input  logic signed [IN1_WIDTH-1:0] in1_i,
   input  logic                        first_i,
   input  logic                        last_i,
   output logic                        valid_o,
   output logic signed [OUT_WIDTH-1:0] result_o,
   output logic                        sat_o
);

   import fir_pkg::*;

   localparam int PROD_WIDTH = IN0_WIDTH + IN1_WIDTH;

   if (!acc_width_ok(ACC_WIDTH, IN0_WIDTH, IN1_WIDTH)) begin : g_bad_acc_width
      $error("mac_pipe: ACC_WIDTH must hold a full product and stay below FIR_MAX_W-1");
   end
   if (!mult_stages_ok(MULT_STAGES)) begin : g_bad_mult_stages
      $error("mac_pipe: MULT_STAGES must be at least 1");
   end

   logic                         m_valid;
   logic                         m_first;
   logic                         m_last;
   logic signed [PROD_WIDTH-1:0] m_product;
   logic signed [ACC_WIDTH-1:0]  prod_ext;
   logic signed [ACC_WIDTH-1:0]  sum;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  sum_q;
   logic                         frame_done;
   sat_round_t                   rounded;

   mult_pipe #(
      .A_WIDTH (IN0_WIDTH),
      .B_WIDTH (IN1_WIDTH),
      .STAGES  (MULT_STAGES)
   ) u_mult (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .valid      (valid_i),
      .first      (first_i),
      .last       (last_i),
      .a          (in0_i),
      .b          (in1_i),
      .prod_valid (m_valid),
      .prod_first (m_first),
      .prod_last  (m_last),
      .product    (m_product)
   );

   // A first beat ignores whatever the accumulator holds; the sum wraps
   // silently in ACC_WIDTH two's complement.
   always_comb begin
      prod_ext = ACC_WIDTH'(m_product);
      sum      = (m_first ? '0 : acc) + prod_ext;
   end

   // Accumulator stage. The running sum clears after a last beat so a
   // following beat without first still starts from zero. The finished
   // frame sum is handed to the output stage with a one-cycle done flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc        <= '0;
         sum_q      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= m_valid && m_last;
         if (m_valid) begin
            acc <= m_last ? '0 : sum;
            if (m_last) begin
               sum_q <= sum;
            end
         end
      end
   end

   always_comb begin
      rounded = sat_round(FIR_MAX_W'(sum_q), OUT_SHIFT, OUT_WIDTH);
   end

   // Output stage: result and clip flag only update on a finished frame and
   // then hold; valid_o is a single-cycle strobe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o  <= 1'b0;
         result_o <= '0;
         sat_o    <= 1'b0;
      end else begin
         valid_o <= frame_done;
         if (frame_done) begin
            result_o <= rounded.value[OUT_WIDTH-1:0];
            sat_o    <= rounded.sat;
         end
      end
   end

endmodule

// File: tb/tb_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_mac_pipe
// Directed bench for mac_pipe: a default-parameter instance plus a wide,
// unshifted instance for the accumulator wrap case.
// ---------------------------------------------------------------------------
module tb_mac_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic               valid_in, first_in, last_in;
   logic signed [15:0] in0, in1;
   logic               valid_out, sat_out;
   logic signed [15:0] result_out;

   logic               w_valid_in, w_first_in, w_last_in;
   logic signed [15:0] w_in0, w_in1;
   logic               w_valid_out, w_sat_out;
   logic signed [31:0] w_result_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      longint res;
      longint sat;
      int     lat;
      int     cyc;
   } out_t;

   int   last_q[$];
   out_t out_q[$];
   out_t mon;

   mac_pipe dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (valid_in),
      .in0_i    (in0),
      .in1_i    (in1),
      .first_i  (first_in),
      .last_i   (last_in),
      .valid_o  (valid_out),
      .result_o (result_out),
      .sat_o    (sat_out)
   );

   mac_pipe #(
      .ACC_WIDTH (32),
      .OUT_WIDTH (32),
      .OUT_SHIFT (0)
   ) dut_wide (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (w_valid_in),
      .in0_i    (w_in0),
      .in1_i    (w_in1),
      .first_i  (w_first_in),
      .last_i   (w_last_in),
      .valid_o  (w_valid_out),
      .result_o (w_result_out),
      .sat_o    (w_sat_out)
   );

   // Cycle counter; a last beat is logged on the edge that captures it,
   // which counts as the first cycle of latency.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && valid_in && last_in) last_q.push_back(cyc);
   end

   // Collect every valid_o strobe together with its measured latency.
   always @(negedge clk) begin
      if (valid_out) begin
         mon.res = result_out;
         mon.sat = sat_out;
         mon.cyc = cyc;
         if (last_q.size() > 0) mon.lat = cyc - last_q.pop_front() + 1;
         else mon.lat = -1;
         out_q.push_back(mon);
      end
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
      end
   endtask

   // Drive one beat at a negedge for exactly one cycle.
   task automatic applyStimulus(input logic v, input logic signed [15:0] a,
                                input logic signed [15:0] b, input logic f, input logic l);
      valid_in = v; in0 = a; in1 = b; first_in = f; last_in = l;
      @(negedge clk);
      valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
   endtask

   task automatic expectResult(input string tag, input longint res, input longint sat,
                               output int at_cyc);
      int   waited = 0;
      out_t o;
      at_cyc = -1;
      while (out_q.size() == 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (out_q.size() == 0) begin
         checkOutput({tag, " timeout"}, out_q.size(), 1);
      end else begin
         o = out_q.pop_front();
         at_cyc = o.cyc;
         checkOutput({tag, " result"}, o.res, res);
         checkOutput({tag, " sat"}, o.sat, sat);
         checkOutput({tag, " latency"}, o.lat, 4);
      end
   endtask

   task automatic applyWide(input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic f, input logic l);
      w_valid_in = 1'b1; w_in0 = a; w_in1 = b; w_first_in = f; w_last_in = l;
      @(negedge clk);
      w_valid_in = 1'b0; w_first_in = 1'b0; w_last_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c0, c1, c2, c3, n;
      rst_n = 1'b0;
      valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0; in0 = '0; in1 = '0;
      w_valid_in = 1'b0; w_first_in = 1'b0; w_last_in = 1'b0; w_in0 = '0; w_in1 = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset valid_o", valid_out, 0);
      checkOutput("reset result_o", result_out, 0);
      checkOutput("reset sat_o", sat_out, 0);
      checkOutput("reset wide valid_o", w_valid_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] single beat");
      applyStimulus(1'b1, 16'sd16384, 16'sd16384, 1'b1, 1'b1);
      expectResult("t1", 8192, 0, c0);

      $display("[TB] saturating frame then small frame");
      applyStimulus(1'b1, 16'sd32767, 16'sd32767, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'sd32767, 16'sd32767, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'sd32767, 16'sd32767, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'sd32767, 16'sd32767, 1'b0, 1'b1);
      applyStimulus(1'b1, 16'sd2, 16'sd16384, 1'b1, 1'b1);
      expectResult("t2 sat frame", 32767, 1, c0);
      expectResult("t2 next frame", 1, 0, c0);

      $display("[TB] rounding, back-to-back single-beat frames");
      applyStimulus(1'b1, -16'sd1, 16'sd16384, 1'b1, 1'b1);
      applyStimulus(1'b1, -16'sd1, 16'sd16385, 1'b1, 1'b1);
      applyStimulus(1'b1, 16'sd1, 16'sd16384, 1'b1, 1'b1);
      applyStimulus(1'b1, -16'sd32768, -16'sd32768, 1'b1, 1'b1);
      expectResult("t3 -1*16384", 0, 0, c0);
      expectResult("t3 -1*16385", -1, 0, c1);
      expectResult("t3 1*16384", 1, 0, c2);
      expectResult("t3 min*min", 32767, 1, c3);
      checkOutput("t3 back-to-back gap", c3 - c0, 3);

      $display("[TB] frames with bubbles");
      applyStimulus(1'b1, 16'sd100, 16'sd200, 1'b1, 1'b0);
      idle(1);
      applyStimulus(1'b1, 16'sd100, 16'sd200, 1'b0, 1'b0);
      idle(3);
      applyStimulus(1'b1, 16'sd100, 16'sd200, 1'b0, 1'b1);
      expectResult("t4 gaps 1/3", 2, 0, c0);
      applyStimulus(1'b1, 16'sd100, 16'sd200, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'sd100, 16'sd200, 1'b0, 1'b0);
      idle(2);
      applyStimulus(1'b1, 16'sd100, 16'sd200, 1'b0, 1'b1);
      expectResult("t4 gaps 0/2", 2, 0, c0);
      idle(5);
      checkOutput("hold result_o", result_out, 2);
      checkOutput("hold valid_o low", valid_out, 0);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 16'sd16384, 16'sd16384, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'sd16384, 16'sd16384, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("t5 reset valid_o", valid_out, 0);
      checkOutput("t5 reset result_o", result_out, 0);
      checkOutput("t5 reset sat_o", sat_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 16'sd16384, 16'sd16384, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'sd16384, 16'sd16384, 1'b0, 1'b1);
      expectResult("t5 fresh frame", 16384, 0, c0);
      applyStimulus(1'b1, 16'sd1, 16'sd16384, 1'b0, 1'b1);
      expectResult("t5 no-first after last", 1, 0, c0);

      $display("[TB] wide accumulator wrap");
      applyWide(-16'sd32768, -16'sd32768, 1'b1, 1'b0);
      applyWide(-16'sd32768, -16'sd32768, 1'b0, 1'b1);
      n = 0;
      while (!w_valid_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t6 latency", n + 1, 4);
      checkOutput("t6 result", w_result_out, -64'sd2147483648);
      checkOutput("t6 sat", w_sat_out, 0);

      idle(6);
      checkOutput("no extra strobes", out_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
